uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
UART receiver (8N1, LSB first) with a byte FIFO on its output. It reconstructs bytes from the serial line i_uart_rxd, checks start and stop bits, and buffers good bytes in a first-word-fall-through FIFO. It sits between the board RX pin and the host-side consumer logic, and is the far end of the serial byte writer used in our UART benches. It adds glitch rejection, framing-error and overflow reporting, and buffering so the consumer can drain bytes at its own rate.

Parameters:
CLKS_PER_BIT, 87, i_clk cycles per serial bit; must be >= 8.
FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and >= 2.
ADDR_W, $clog2(FIFO_DEPTH), derived FIFO pointer width; not overridden.

Ports:
i_clk  input  1  system clock; all logic is on the rising edge.
i_rst  input  1  synchronous reset, active-high.
i_uart_rxd  input  1  asynchronous serial line; idles high.
i_rd_en  input  1  pops the head entry when o_rd_valid=1.
i_ovf_clr  input  1  clears o_overflow.
o_rd_byte  output  8  FIFO head byte; valid only while o_rd_valid=1.
o_rd_valid  output  1  FIFO not empty.
o_fifo_count  output  ADDR_W+1  number of occupied entries, 0..FIFO_DEPTH.
o_frame_err  output  1  1-cycle pulse when a received stop bit is 0.
o_overflow  output  1  sticky flag: a good byte was dropped because the FIFO was full.
o_rx_active  output  1  high while the FSM is in any state other than IDLE.

Behaviour:
- Reset (i_rst=1 at a clock edge) forces:
  - FSM to IDLE; pointers, count and bit counter to 0; both synchronizer flops to 1.
  - Outputs: o_rd_valid=0, o_fifo_count=0, o_rd_byte=0x00, o_frame_err=0, o_overflow=0, o_rx_active=0.
- Reset mid-frame abandons the partial byte. Reception restarts only on a new falling edge, after the synchronizer has seen the line high.
- Synchronizer: two flops on i_uart_rxd. All FSM decisions use the second flop (rx_s).
- Clock counter: 0..CLKS_PER_BIT-1. Bit index: 0..7.
- FSM states:
  - IDLE: if rx_s=0, go to START and clear the clock counter.
  - START: count to (CLKS_PER_BIT-1)/2, which is 43 at the default.
    - If rx_s=0 there, go to DATA and clear the counter.
    - If rx_s=1, it was a glitch: return to IDLE with no output.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift bit[index], LSB first.
    - After index 7, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse o_frame_err for one cycle, discard the byte, go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. This prevents a held-low line from spawning false frames.
- Push rules:
  - Push occurs on the stop-sample cycle.
  - o_rd_valid and o_fifo_count update on the following edge.
  - Push-to-valid latency is 1 cycle.
  - End-to-end: o_rd_valid rises within 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 cycles of the line's falling edge. At the default this is 830 cycles, ±1 allowed.
- FIFO (first-word fall-through):
  - o_rd_byte shows the head entry combinationally from storage.
  - A pop occurs when i_rd_en=1 and o_rd_valid=1; the head advances on that edge.
  - i_rd_en while empty is ignored: no pointer change, no underflow.
  - Pointers wrap modulo FIFO_DEPTH. Count is tracked separately, so full (count=FIFO_DEPTH) and empty (count=0) are unambiguous.
  - Push with pop on the same cycle: both occur and count is unchanged. This holds when full (the new byte is accepted) and when empty (pop ignored, count becomes 1).
  - Push when full with no pop: the byte is dropped, storage is untouched, and o_overflow is set on the next edge.
- o_overflow clearing:
  - Cleared by i_ovf_clr=1 or by reset.
  - If a drop and i_ovf_clr occur on the same cycle, set wins.
- o_frame_err and overflow never both assert for the same frame.

Test Plan:
- Single frame 0x3F at 87 clks/bit after reset -> o_rd_valid rises at ~830 cycles, o_rd_byte=0x3F, o_fifo_count=1. Then i_rd_en for 1 cycle -> o_rd_valid=0, count=0.
- Back-to-back frames 0xAB, 0x55, 0x00, 0xFF with no idle gap and no reads -> count=4. Four pops return exactly that order; o_frame_err and o_overflow stay 0 throughout.
- 20-cycle low glitch on an idle line -> FSM returns to IDLE, no push, no o_frame_err. The next valid frame 0xA5 is received correctly.
- Frame 0x81 with stop bit 0, line then held low for 3 bit times -> one o_frame_err pulse, count stays 0, o_rx_active stays high until the line returns high. A following 0x42 is received correctly.
- 17 frames (0x00..0x10) with no reads, FIFO_DEPTH=16 -> count=16, o_overflow=1, pops return 0x00..0x0F. Then i_ovf_clr -> o_overflow=0. Repeat, with i_rd_en pulsed on the 17th frame's push cycle -> byte accepted, count stays 16, o_overflow stays 0.
- Assert i_rst during the DATA state of frame 0xC3 with 2 bytes queued -> all outputs return to reset values, queued bytes are lost. The next frame 0x5A yields count=1 and o_rd_byte=0x5A.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first) feeding a first-word-fall-through byte FIFO.
// Rejects start-bit glitches, reports framing errors and FIFO overflow.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_uart_rxd,
  input  logic              i_rd_en,
  input  logic              i_ovf_clr,
  output logic [7:0]        o_rd_byte,
  output logic              o_rd_valid,
  output logic [ADDR_W:0]   o_fifo_count,
  output logic              o_frame_err,
  output logic              o_overflow,
  output logic              o_rx_active
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state, state_d;
  logic             sync1, rx_s;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift, shift_d;
  logic             push, frame_err_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_frame_err <= 1'b0;
    end else begin
      sync1       <= i_uart_rxd;
      rx_s        <= sync1;
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      shift       <= shift_d;
      o_frame_err <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    shift_d     = shift;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state)
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d   = '0;
      end
      // Re-check the line at mid start bit so short low glitches are ignored.
      START: if (cnt == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end else cnt_d = cnt + 1'b1;
      DATA: if (cnt == LAST) begin
        cnt_d        = '0;
        shift_d[idx] = rx_s;
        idx_d        = idx + 1'b1;
        if (idx == 3'd7) state_d = STOP;
      end else cnt_d = cnt + 1'b1;
      STOP: if (cnt == LAST) begin
        cnt_d = '0;
        if (rx_s) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BRK;
        end
      end else cnt_d = cnt + 1'b1;
      // A held-low line (break) must return high before a new frame can start.
      BRK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   count;
  logic              pop, wr, full;

  assign full = (count == FULL);
  assign pop  = i_rd_en && (count != '0);
  // When full, a simultaneous pop frees the slot the new byte lands in.
  assign wr   = push && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (pop && !wr) count <= count - 1'b1;
      if (push && !wr)     o_overflow <= 1'b1;
      else if (i_ovf_clr)  o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr) mem[wptr] <= shift;
  end

  assign o_rd_valid   = (count != '0);
  assign o_rd_byte    = o_rd_valid ? mem[rptr] : 8'h00;
  assign o_fifo_count = count;
  assign o_rx_active  = (state != IDLE);
endmodule
